// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared state encoding, AXI response/burst codes and slave-port bundles
package axi_slave_pkg;
  localparam int IDS_BITS = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  typedef enum logic [1:0] {IDLE, R_CH, W_CH, B_CH} state_t;
  typedef struct packed {
    logic [IDS_BITS-1:0] awid;
    logic [AXI_ADDR_BITS-1:0] awaddr;
    logic [AXI_LEN_BITS-1:0] awlen;
    logic [1:0] awburst;
    logic awvalid;
    logic [AXI_DATA_BITS-1:0] wdata;
    logic [AXI_DATA_BITS/8-1:0] wstrb;
    logic wlast;
    logic wvalid;
    logic bready;
    logic [IDS_BITS-1:0] arid;
    logic [AXI_ADDR_BITS-1:0] araddr;
    logic [AXI_LEN_BITS-1:0] arlen;
    logic [1:0] arburst;
    logic arvalid;
    logic rready;
  } s2axi_in_t;
  typedef struct packed {
    logic awready;
    logic wready;
    logic arready;
    logic [IDS_BITS-1:0] bid;
    logic [1:0] bresp;
    logic bvalid;
    logic [IDS_BITS-1:0] rid;
    logic [AXI_DATA_BITS-1:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    logic rvalid;
  } s2axi_out_t;
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next word address for FIXED/INCR bursts (WRAP advances like INCR)
module axi_burst_addr
  import axi_slave_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic [ADDR_BITS-1:0] cur_addr,
  input  logic [1:0]           burst,
  input  logic                 adv,
  output logic [ADDR_BITS-1:0] next_addr
);
  assign next_addr = (adv && burst != BURST_FIXED) ? cur_addr + 1'b1 : cur_addr;
endmodule

// File: rtl/sram_axi_slave.sv
// sram_axi_slave: AXI4 slave to single-port sync SRAM bridge; SRAM_AXI_RESP_ERR_EN enables SLVERR on WRAP/mismatched wlast
module sram_axi_slave
  import axi_slave_pkg::*;
#(
  parameter int ADDR_BITS = 14,
  parameter int DATA_BITS = AXI_DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  s2axi_in_t              s2axi_i,
  output s2axi_out_t             s2axi_o,
  output logic                   sram_cs,
  output logic                   sram_oe,
  output logic [DATA_BITS/8-1:0] sram_web,
  output logic [ADDR_BITS-1:0]   sram_a,
  output logic [DATA_BITS-1:0]   sram_di,
  input  logic [DATA_BITS-1:0]   sram_do
);
`ifdef SRAM_AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  state_t state, state_nx;
  logic [ADDR_BITS-1:0] cur_addr, next_addr;
  logic [3:0] len, beat_cnt;
  logic [1:0] burst;
  logic [IDS_BITS-1:0] id;
  logic err, awhns, arhns, rhns, whns, bhns, rlast, ar_wrap, aw_wrap, wlast_bad, w_en, unused;
  assign awhns = state == IDLE && s2axi_i.awvalid;
  assign arhns = state == IDLE && s2axi_i.arvalid && !s2axi_i.awvalid;
  assign rhns = state == R_CH && s2axi_i.rready;
  assign whns = state == W_CH && s2axi_i.wvalid;
  assign bhns = state == B_CH && s2axi_i.bready;
  assign rlast = state == R_CH && beat_cnt == len;
  assign ar_wrap = ERR_EN && s2axi_i.arburst == BURST_WRAP;
  assign aw_wrap = ERR_EN && s2axi_i.awburst == BURST_WRAP;
  assign wlast_bad = ERR_EN && whns && s2axi_i.wlast && beat_cnt != len;
  assign w_en = whns && !err && beat_cnt <= len;
  assign unused = ^{s2axi_i.awaddr[AXI_ADDR_BITS-1:ADDR_BITS+2], s2axi_i.awaddr[1:0],
                    s2axi_i.araddr[AXI_ADDR_BITS-1:ADDR_BITS+2], s2axi_i.araddr[1:0]};
  axi_burst_addr #(.ADDR_BITS(ADDR_BITS)) u_addr (
    .cur_addr (cur_addr),
    .burst    (burst),
    .adv      (rhns || whns),
    .next_addr(next_addr)
  );
  // state register plus burst context latched on address handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      len <= '0;
      burst <= BURST_FIXED;
      id <= '0;
      beat_cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (awhns || arhns) begin
        cur_addr <= awhns ? s2axi_i.awaddr[ADDR_BITS+1:2] : s2axi_i.araddr[ADDR_BITS+1:2];
        len <= awhns ? s2axi_i.awlen : s2axi_i.arlen;
        burst <= awhns ? s2axi_i.awburst : s2axi_i.arburst;
        id <= awhns ? s2axi_i.awid : s2axi_i.arid;
        beat_cnt <= '0;
        err <= awhns ? aw_wrap : ar_wrap;
      end else if (rhns || whns) begin
        cur_addr <= next_addr;
        beat_cnt <= beat_cnt + 4'd1;
        err <= err || wlast_bad;
      end
    end
  end
  // next state, AXI channel outputs and SRAM strobes
  always_comb begin
    state_nx = awhns ? W_CH : arhns ? R_CH : (rhns && rlast) ? IDLE :
               (whns && s2axi_i.wlast) ? B_CH : bhns ? IDLE : state;
    s2axi_o = '0;
    s2axi_o.awready = state == IDLE;
    s2axi_o.arready = state == IDLE && !s2axi_i.awvalid;
    s2axi_o.wready = state == W_CH;
    s2axi_o.bvalid = state == B_CH;
    s2axi_o.bid = id;
    s2axi_o.bresp = err ? RESP_SLVERR : RESP_OKAY;
    s2axi_o.rvalid = state == R_CH;
    s2axi_o.rid = id;
    s2axi_o.rdata = err ? '0 : sram_do;
    s2axi_o.rresp = err ? RESP_SLVERR : RESP_OKAY;
    s2axi_o.rlast = rlast;
    sram_cs = arhns ? !ar_wrap : state == R_CH ? !err : w_en;
    sram_oe = arhns ? !ar_wrap : state == R_CH && !err;
    sram_web = w_en ? ~s2axi_i.wstrb : '1;
    sram_a = arhns ? s2axi_i.araddr[ADDR_BITS+1:2] : state == R_CH ? next_addr : cur_addr;
    sram_di = s2axi_i.wdata;
  end
endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave: directed scoreboard bench for sram_axi_slave with a behavioural SRAM
module tb_sram_axi_slave;
  import axi_slave_pkg::*;
`ifdef SRAM_AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef struct {
    logic [31:0] d;
    logic last;
    logic [1:0] resp;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  s2axi_in_t ai;
  s2axi_out_t ao;
  logic sram_cs, sram_oe;
  logic [3:0] sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di, sram_do;
  logic [31:0] mem [0:16383];
  exp_t q[$];
  int total = 0, bad = 0;
  bit ok;
  always #5 clk = ~clk;
  sram_axi_slave dut (
    .clk(clk), .rst(rst), .s2axi_i(ai), .s2axi_o(ao),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );
  always @(posedge clk) begin
    if (sram_cs && sram_oe) sram_do <= mem[sram_a];
    for (int b = 0; b < 4; b++)
      if (sram_cs && !sram_web[b]) mem[sram_a][8*b+:8] <= sram_di[8*b+:8];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic sigsel(input int w);
    return w == 0 ? ao.awready : w == 1 ? ao.wready : w == 2 ? ao.arready : ao.bvalid;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_sig(input int w, input string tag);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sigsel(w);
    end
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL timeout_%s observed=0 expected=1", tag);
    end
  endtask
  task automatic push_exp(input logic [31:0] d, input logic last, input logic [1:0] resp);
    exp_t e;
    e.d = d;
    e.last = last;
    e.resp = resp;
    q.push_back(e);
  endtask
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input int nbeats, input logic [31:0] d, input logic [3:0] strb,
                           input logic [1:0] eresp, input logic [7:0] id);
    ai.awid = id;
    ai.awaddr = addr;
    ai.awlen = len;
    ai.awburst = burst;
    ai.awvalid = 1'b1;
    wait_sig(0, "aw");
    step();
    ai.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      ai.wdata = d + i;
      ai.wstrb = strb;
      ai.wlast = i == nbeats - 1;
      ai.wvalid = 1'b1;
      wait_sig(1, "w");
      step();
    end
    ai.wvalid = 1'b0;
    ai.wlast = 1'b0;
    ai.bready = 1'b1;
    wait_sig(3, "b");
    chk("bresp", ao.bresp, eresp);
    chk("bid", ao.bid, id);
    step();
    ai.bready = 1'b0;
  endtask
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [7:0] id, input logic [6:0] pat, input int plen);
    exp_t e;
    int beats = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    ai.arid = id;
    ai.araddr = addr;
    ai.arlen = len;
    ai.arburst = burst;
    ai.arvalid = 1'b1;
    wait_sig(2, "ar");
    step();
    ai.arvalid = 1'b0;
    while (beats <= int'(len) && cyc < 60) begin
      ai.rready = pat[cyc%plen];
      @(negedge clk);
      if (cyc == 0) chk("r_first_valid", ao.rvalid, 1);
      if (stalled) chk("r_stable", ao.rdata, held);
      if (ao.rvalid && ai.rready) begin
        if (q.size() == 0) chk("r_unexpected", ao.rdata, 'x);
        else begin
          e = q.pop_front();
          chk("rdata", ao.rdata, e.d);
          chk("rlast", ao.rlast, e.last);
          chk("rresp", ao.rresp, e.resp);
          chk("rid", ao.rid, id);
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = ao.rvalid;
        held = ao.rdata;
      end
      step();
      cyc++;
    end
    ai.rready = 1'b0;
    if (beats <= int'(len)) chk("r_timeout_beats", beats, len + 1);
  endtask
  initial begin
    ai = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_rvalid", ao.rvalid, 0);
    chk("rst_bvalid", ao.bvalid, 0);
    chk("rst_rlast", ao.rlast, 0);
    chk("rst_web", sram_web, 4'hF);
    chk("rst_cs", sram_cs, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_awready", ao.awready, 1);
    chk("rst_resp", {ao.bresp, ao.rresp}, 0);
    step();
    rst = 1'b0;
    step();
    // single write then single read
    axi_write(32'h10, 0, BURST_INCR, 1, 32'hDEADBEEF, 4'hF, RESP_OKAY, 8'h3);
    push_exp(32'hDEADBEEF, 1, RESP_OKAY);
    axi_read(32'h10, 0, BURST_INCR, 8'h7, 7'h7F, 1);
    // INCR burst with rready stalls 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++)
      axi_write(32'h20 + 4 * i, 0, BURST_INCR, 1, i + 1, 4'hF, RESP_OKAY, 8'h1);
    for (int i = 0; i < 4; i++) push_exp(i + 1, i == 3, RESP_OKAY);
    axi_read(32'h20, 3, BURST_INCR, 8'h2, 7'b1011001, 7);
    // FIXED burst repeats one word
    axi_write(32'h40, 0, BURST_INCR, 1, 32'hA5A5A5A5, 4'hF, RESP_OKAY, 8'h4);
    for (int i = 0; i < 4; i++) push_exp(32'hA5A5A5A5, i == 3, RESP_OKAY);
    axi_read(32'h40, 3, BURST_FIXED, 8'h5A, 7'h7F, 1);
    // partial strobe merge
    axi_write(32'h50, 0, BURST_INCR, 1, 32'h11223344, 4'hF, RESP_OKAY, 8'h6);
    axi_write(32'h50, 0, BURST_INCR, 1, 32'h0000AB00, 4'b0010, RESP_OKAY, 8'h6);
    push_exp(32'h1122AB44, 1, RESP_OKAY);
    axi_read(32'h50, 0, BURST_INCR, 8'h8, 7'h7F, 1);
    // word address wraps to 0 at the top of the SRAM
    axi_write(32'h0, 0, BURST_INCR, 1, 32'h0BAD0000, 4'hF, RESP_OKAY, 8'h9);
    axi_write(32'hFFFC, 0, BURST_INCR, 1, 32'hCAFEF00D, 4'hF, RESP_OKAY, 8'h9);
    push_exp(32'hCAFEF00D, 0, RESP_OKAY);
    push_exp(32'h0BAD0000, 1, RESP_OKAY);
    axi_read(32'hFFFC, 1, BURST_INCR, 8'hA, 7'h7F, 1);
    // extra write beat past awlen is accepted but not written
    axi_write(32'h64, 0, BURST_INCR, 1, 32'h12345678, 4'hF, RESP_OKAY, 8'hB);
    axi_write(32'h60, 0, BURST_INCR, 2, 32'h77, 4'hF, ERR_EN ? RESP_SLVERR : RESP_OKAY, 8'hC);
    push_exp(32'h77, 0, RESP_OKAY);
    push_exp(32'h12345678, 1, RESP_OKAY);
    axi_read(32'h60, 1, BURST_INCR, 8'hD, 7'h7F, 1);
    // AW and AR together: write wins, read waits for the B handshake
    ai.awid = 8'hE;
    ai.awaddr = 32'h70;
    ai.awlen = 0;
    ai.awburst = BURST_INCR;
    ai.awvalid = 1'b1;
    ai.arid = 8'hF;
    ai.araddr = 32'h70;
    ai.arlen = 0;
    ai.arburst = BURST_INCR;
    ai.arvalid = 1'b1;
    @(negedge clk);
    chk("tie_awready", ao.awready, 1);
    chk("tie_arready", ao.arready, 0);
    step();
    ai.awvalid = 1'b0;
    ai.wdata = 32'h13579BDF;
    ai.wstrb = 4'hF;
    ai.wlast = 1'b1;
    ai.wvalid = 1'b1;
    @(negedge clk);
    chk("tie_w_arready", ao.arready, 0);
    step();
    ai.wvalid = 1'b0;
    ai.wlast = 1'b0;
    ai.bready = 1'b1;
    @(negedge clk);
    chk("tie_bvalid", ao.bvalid, 1);
    chk("tie_b_arready", ao.arready, 0);
    step();
    ai.bready = 1'b0;
    push_exp(32'h13579BDF, 1, RESP_OKAY);
    axi_read(32'h70, 0, BURST_INCR, 8'hF, 7'h7F, 1);
    // reset during beat 2 of a 4-beat read
    ai.arid = 8'h11;
    ai.araddr = 32'h20;
    ai.arlen = 3;
    ai.arburst = BURST_INCR;
    ai.arvalid = 1'b1;
    wait_sig(2, "ar_rst");
    step();
    ai.arvalid = 1'b0;
    ai.rready = 1'b1;
    @(negedge clk);
    chk("rst_beat1", ao.rdata, 1);
    step();
    @(negedge clk);
    chk("rst_beat2_valid", ao.rvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", ao.rvalid, 0);
    chk("rst_mid_cs", sram_cs, 0);
    step();
    rst = 1'b0;
    ai.rready = 1'b0;
    @(negedge clk);
    chk("rst_after_arready", ao.arready, 1);
    step();
    push_exp(32'hDEADBEEF, 1, RESP_OKAY);
    axi_read(32'h10, 0, BURST_INCR, 8'h12, 7'h7F, 1);
    // WRAP: error response with zero data, or plain INCR when errors are disabled
    if (ERR_EN) begin
      push_exp(32'h0, 0, RESP_SLVERR);
      push_exp(32'h0, 1, RESP_SLVERR);
    end else begin
      push_exp(1, 0, RESP_OKAY);
      push_exp(2, 1, RESP_OKAY);
    end
    axi_read(32'h20, 1, BURST_WRAP, 8'h13, 7'h7F, 1);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
